fifo_pkt_reader: RTL and testbench

Consumer-side engine for the `fallthrough_small_fifo` in the MPI datapath. It pops 72-bit words (8-bit ctrl + 64-bit data) from the FIFO read port and frames them into packets. It drives them onto the downstream `out_*` datapath bus with `out_rdy` backpressure, and starts new packets only at packet boundaries while enabled. Malformed leading words are discarded and flagged.

---
 rtl/fifo_pkt_reader.sv | 202 ++++++++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: pops {ctrl,data} words from a fall-through FIFO and frames them into packets.
// Optional statistics counters are built only when FIFO_PKT_READER_STATS_EN is defined.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic                             tx_enable,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic                             in_packet,
    output logic                             drop_err,
    output logic [31:0]                      pkt_count,
    output logic [31:0]                      word_count,
    output logic [15:0]                      drop_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_BODY
    } state_e;

    state_e state_q, state_d;

    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  ctrl_zero;

    logic pop;
    logic fwd;
    logic drop;
    logic eop;

    logic                  run_q;
    logic                  out_wr_q;
    logic                  drop_err_q;
    logic                  in_packet_q, in_packet_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;

    assign head_ctrl = fifo_dout[CTRL_WIDTH+DATA_WIDTH-1 -: CTRL_WIDTH];
    assign head_data = fifo_dout[DATA_WIDTH-1:0];
    assign ctrl_zero = (head_ctrl == '0);

    // Holds the reader quiet for the cycle after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM outputs: which action the head word gets this cycle.
    always_comb begin
        pop  = 1'b0;
        fwd  = 1'b0;
        drop = 1'b0;
        eop  = 1'b0;
        if (run_q && !fifo_empty) begin
            unique case (state_q)
                S_IDLE: begin
                    if (ctrl_zero) begin
                        // Stale body word outside a packet: flush it.
                        pop  = 1'b1;
                        drop = 1'b1;
                    end else if (tx_enable && out_rdy) begin
                        pop = 1'b1;
                        fwd = 1'b1;
                    end
                end
                S_HDR: begin
                    if (out_rdy) begin
                        pop = 1'b1;
                        fwd = 1'b1;
                    end
                end
                S_BODY: begin
                    if (out_rdy) begin
                        pop = 1'b1;
                        fwd = 1'b1;
                        eop = !ctrl_zero;
                    end
                end
                default: begin
                    pop = 1'b0;
                end
            endcase
        end
    end

    // FSM next state, advancing only on popped words.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fwd) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (fwd && ctrl_zero) begin
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (eop) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // in_packet stays up through the EOP write, then drops.
    always_comb begin
        in_packet_d = (state_d != S_IDLE) || eop;
    end

    // Output register stage: one cycle from pop to out_wr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr_q    <= 1'b0;
            drop_err_q  <= 1'b0;
            in_packet_q <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
        end else begin
            out_wr_q    <= fwd;
            drop_err_q  <= drop;
            in_packet_q <= in_packet_d;
            if (fwd) begin
                out_data_q <= head_data;
                out_ctrl_q <= head_ctrl;
            end
        end
    end

    assign fifo_rd_en = pop;
    assign out_wr     = out_wr_q;
    assign drop_err   = drop_err_q;
    assign in_packet  = in_packet_q;
    assign out_data   = out_data_q;
    assign out_ctrl   = out_ctrl_q;

`ifdef FIFO_PKT_READER_STATS_EN

    logic [31:0] pkt_count_q,  pkt_count_d;
    logic [31:0] word_count_q, word_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    // Free-running wrap-around counters.
    always_comb begin
        pkt_count_d  = pkt_count_q + {31'd0, eop};
        word_count_d = word_count_q + {31'd0, fwd};
        drop_count_d = drop_count_q + {15'd0, drop};
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count_q  <= '0;
            word_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            word_count_q <= word_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign word_count = word_count_q;
    assign drop_count = drop_count_q;

`else

    assign pkt_count  = '0;
    assign word_count = '0;
    assign drop_count = '0;

`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader: a FIFO model feeds directed packets,
// a negedge monitor pops expected words and drop pulses as the DUT emits them.
module tb_fifo_pkt_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [71:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        tx_enable = 1'b0;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b0;
    logic        in_packet;
    logic        drop_err;
    logic [31:0] pkt_count;
    logic [31:0] word_count;
    logic [15:0] drop_count;

    fifo_pkt_reader #(.DATA_WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_enable  (tx_enable),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .in_packet  (in_packet),
        .drop_err   (drop_err),
        .pkt_count  (pkt_count),
        .word_count (word_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    logic [71:0] mem [256];
    int          wp = 0;
    int          rp = 0;
    int          pops = 0;
    logic        rdy_at_edge = 1'b0;

    assign fifo_empty = (wp == rp);
    assign fifo_dout  = mem[rp[7:0]];

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rp   <= rp + 1;
            pops <= pops + 1;
        end
        rdy_at_edge <= out_rdy;
    end

    int          total = 0;
    int          passed = 0;
    logic [71:0] exp_q [$];
    int          drops_pending = 0;
    int          exp_pkt = 0;
    int          exp_word = 0;
    int          exp_drop = 0;
    int          inpkt_cycles = 0;
    int          first_wr = -1;
    int          last_wr = -1;
    int          cyc = 0;
    logic [71:0] e;

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic chk_cnt(input string tag);
`ifdef FIFO_PKT_READER_STATS_EN
        chk({tag, "_pkt_count"}, 72'(pkt_count), 72'(exp_pkt));
        chk({tag, "_word_count"}, 72'(word_count), 72'(exp_word));
        chk({tag, "_drop_count"}, 72'(drop_count), 72'(exp_drop));
`else
        chk({tag, "_pkt_count"}, 72'(pkt_count), 72'd0);
        chk({tag, "_word_count"}, 72'(word_count), 72'd0);
        chk({tag, "_drop_count"}, 72'(drop_count), 72'd0);
`endif
    endtask

    task automatic push(input logic [7:0] c, input logic [63:0] d,
                        input bit fwd);
        mem[wp[7:0]] = {c, d};
        wp++;
        if (fwd) exp_q.push_back({c, d});
        else drops_pending++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((wp != rp || exp_q.size() != 0 || drops_pending != 0)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_drained"}, 72'(n < 200), 72'd1);
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pops < target && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pop_wait", 72'(pops >= target), 72'd1);
    endtask

    // Monitor: every write and drop pulse must match the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (out_wr) begin
                chk("wr_after_rdy", 72'(rdy_at_edge), 72'd1);
                chk("inpkt_with_wr", 72'(in_packet), 72'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 72'(out_wr), 72'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {out_ctrl, out_data}, e);
                end
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (drop_err) begin
                chk("drop_no_wr", 72'(out_wr), 72'd0);
                if (drops_pending == 0) chk("unexpected_drop", 72'(drop_err), 72'd0);
                else drops_pending--;
            end
            if (in_packet) inpkt_cycles++;
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int base;
    int b2;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state, with a stale word already at the FIFO head.
        push(8'h00, 64'h0BAD, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 72'(fifo_rd_en), 72'd0);
        chk("rst_out_wr", 72'(out_wr), 72'd0);
        chk("rst_drop_err", 72'(drop_err), 72'd0);
        chk("rst_in_packet", 72'(in_packet), 72'd0);
        chk("rst_out_data", 72'(out_data), 72'd0);
        chk("rst_out_ctrl", 72'(out_ctrl), 72'd0);
        chk_cnt("rst");
        reset = 1'b1;
        drain("rst_flush");
        exp_drop = 1;
        chk_cnt("rst_flush");

        // Basic packet.
        tx_enable = 1'b1;
        out_rdy = 1'b1;
        inpkt_cycles = 0;
        first_wr = -1;
        push(8'hFF, 64'h01, 1'b1);
        push(8'h00, 64'h02, 1'b1);
        push(8'h00, 64'h03, 1'b1);
        push(8'h01, 64'h04, 1'b1);
        drain("basic");
        exp_pkt += 1;
        exp_word += 4;
        chk_cnt("basic");
        chk("basic_inpkt_cycles", 72'(inpkt_cycles), 72'd4);
        chk("basic_back_to_back", 72'(last_wr - first_wr), 72'd3);

        // Backpressure after the second pop.
        base = pops;
        push(8'hFF, 64'h10, 1'b1);
        push(8'h00, 64'h11, 1'b1);
        push(8'h00, 64'h12, 1'b1);
        push(8'h01, 64'h13, 1'b1);
        wait_pops(base + 2);
        out_rdy = 1'b0;
        b2 = pops;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_pop_in_hold", 72'(pops - b2), 72'd0);
        out_rdy = 1'b1;
        drain("bp");
        exp_pkt += 1;
        exp_word += 4;
        chk_cnt("bp");

        // tx_enable gate only acts at packet boundaries.
        base = pops;
        push(8'hFF, 64'h20, 1'b1);
        push(8'h00, 64'h21, 1'b1);
        push(8'h00, 64'h22, 1'b1);
        push(8'h01, 64'h23, 1'b1);
        push(8'hFF, 64'h30, 1'b1);
        push(8'h00, 64'h31, 1'b1);
        push(8'h00, 64'h32, 1'b1);
        push(8'h01, 64'h33, 1'b1);
        wait_pops(base + 1);
        tx_enable = 1'b0;
        repeat (12) @(negedge clk);
        chk("gate_first_pkt_pops", 72'(pops - base), 72'd4);
        chk("gate_second_held", 72'(wp - rp), 72'd4);
        tx_enable = 1'b1;
        drain("gate");
        exp_pkt += 2;
        exp_word += 8;
        chk_cnt("gate");

        // Malformed head while disabled.
        tx_enable = 1'b0;
        base = pops;
        push(8'h00, 64'hAA, 1'b0);
        push(8'hFF, 64'h40, 1'b1);
        repeat (5) @(negedge clk);
        chk("mal_one_pop", 72'(pops - base), 72'd1);
        chk("mal_drop_seen", 72'(drops_pending), 72'd0);
        exp_drop += 1;
        chk_cnt("mal_held");
        push(8'h00, 64'h41, 1'b1);
        push(8'h01, 64'h42, 1'b1);
        tx_enable = 1'b1;
        drain("mal");
        exp_pkt += 1;
        exp_word += 3;
        chk_cnt("mal");

        // Reset in the middle of a packet body.
        push(8'hFF, 64'h50, 1'b1);
        push(8'h00, 64'h51, 1'b1);
        push(8'h00, 64'h52, 1'b1);
        drain("mid_pre");
        chk("mid_in_packet", 72'(in_packet), 72'd1);
        out_rdy = 1'b0;
        push(8'h00, 64'h53, 1'b0);
        push(8'h00, 64'h54, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_wr", 72'(out_wr), 72'd0);
        chk("mid_rst_in_packet", 72'(in_packet), 72'd0);
        chk("mid_rst_out_data", 72'(out_data), 72'd0);
        chk("mid_rst_out_ctrl", 72'(out_ctrl), 72'd0);
        chk("mid_rst_rd_en", 72'(fifo_rd_en), 72'd0);
        exp_pkt = 0;
        exp_word = 0;
        exp_drop = 0;
        chk_cnt("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        drain("mid_residual");
        exp_drop = 2;
        chk_cnt("mid_residual");
        out_rdy = 1'b1;
        push(8'hFF, 64'h60, 1'b1);
        push(8'h00, 64'h61, 1'b1);
        push(8'h01, 64'h62, 1'b1);
        drain("mid_clean");
        exp_pkt = 1;
        exp_word = 3;
        chk_cnt("mid_clean");
        chk("final_in_packet", 72'(in_packet), 72'd0);
        chk("final_scoreboard_empty", 72'(exp_q.size()), 72'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
